// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life window generator and rule logic.
// Neighbour bit order is fixed here so producer and consumer cannot disagree.
package life_pkg;

  typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_t;

  localparam int NB_NW = 0;
  localparam int NB_N  = 1;
  localparam int NB_NE = 2;
  localparam int NB_W  = 3;
  localparam int NB_E  = 4;
  localparam int NB_SW = 5;
  localparam int NB_S  = 6;
  localparam int NB_SE = 7;

  // Row offset of neighbour k relative to the centre cell.
  function automatic int nb_dr(input int k);
    case (k)
      NB_NW, NB_N, NB_NE: return -1;
      NB_W, NB_E:         return 0;
      default:            return 1;
    endcase
  endfunction

  // Column offset of neighbour k relative to the centre cell.
  function automatic int nb_dc(input int k);
    case (k)
      NB_NW, NB_W, NB_SW: return -1;
      NB_N, NB_S:         return 0;
      default:            return 1;
    endcase
  endfunction

endpackage

// File: rtl/life_nb_fetch.sv
// Combinational 3x3 neighbourhood decode from the frame buffer at (r,c).
// LIFE_WIN_TORUS_EN selects a toroidal board; otherwise off-board cells are dead.
module life_nb_fetch
  import life_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int RW     = $clog2(HEIGHT),
  parameter int CW     = $clog2(WIDTH)
) (
  input  logic [WIDTH*HEIGHT-1:0] fb,
  input  logic [RW-1:0]           r,
  input  logic [CW-1:0]           c,
  output logic                    self,
  output logic [7:0]              n
);

  localparam int IW = $clog2(WIDTH*HEIGHT);

  int rr;
  int cc;

  always_comb begin
    rr   = 0;
    cc   = 0;
    n    = '0;
    self = fb[IW'(int'(r) * WIDTH + int'(c))];
    for (int k = 0; k < 8; k++) begin
      rr = int'(r) + nb_dr(k);
      cc = int'(c) + nb_dc(k);
`ifdef LIFE_WIN_TORUS_EN
      if (rr < 0) rr = HEIGHT - 1;
      else if (rr >= HEIGHT) rr = 0;
      if (cc < 0) cc = WIDTH - 1;
      else if (cc >= WIDTH) cc = 0;
      n[k] = fb[IW'(rr * WIDTH + cc)];
`else
      if (rr >= 0 && rr < HEIGHT && cc >= 0 && cc < WIDTH)
        n[k] = fb[IW'(rr * WIDTH + cc)];
`endif
    end
  end

endmodule

// File: rtl/life_window_gen.sv
// Loads a raster board into a frame buffer, then replays one 3x3 window per cell.
// Build option LIFE_WIN_TORUS_EN (see life_nb_fetch) wraps the board edges.
module life_window_gen
  import life_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_cell,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_self,
  output logic [7:0] out_n,
  output logic       out_last
);

  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);
  localparam int IW = $clog2(WIDTH*HEIGHT);

  state_t                  state;
  logic [RW-1:0]           r;
  logic [CW-1:0]           c;
  logic [WIDTH*HEIGHT-1:0] fb;
  logic                    at_last;
  logic                    at_eol;
  logic                    f_self;
  logic [7:0]              f_n;

  assign at_eol  = (c == CW'(WIDTH - 1));
  assign at_last = at_eol && (r == RW'(HEIGHT - 1));

  // Frame buffer is never cleared: every cell is rewritten before EMIT reads it.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready)
      fb[IW'(int'(r) * WIDTH + int'(c))] <= in_cell;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      r         <= '0;
      c         <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            if (at_last) begin
              r         <= '0;
              c         <= '0;
              state     <= EMIT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else if (at_eol) begin
              c <= '0;
              r <= r + 1'b1;
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (at_last) begin
              r         <= '0;
              c         <= '0;
              state     <= LOAD;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
            end else if (at_eol) begin
              c <= '0;
              r <= r + 1'b1;
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  life_nb_fetch #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_fetch (
    .fb   (fb),
    .r    (r),
    .c    (c),
    .self (f_self),
    .n    (f_n)
  );

  // Window outputs are held at zero outside EMIT so they only move on handshakes.
  assign out_self = out_valid & f_self;
  assign out_n    = out_valid ? f_n : 8'h00;
  assign out_last = out_valid & at_last;

endmodule

// File: tb/tb_life_window_gen.sv
// Scoreboard bench for life_window_gen: 8x8 instance for most steps, 3x3 for the minimum board.
module tb_life_window_gen;

  typedef struct packed {
    logic       self;
    logic [7:0] n;
    logic       last;
  } win_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_cell = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid, out_self, out_last;
  logic [7:0] out_n;
  logic       in_valid3 = 1'b0, in_cell3 = 1'b0, out_ready3 = 1'b0;
  logic       in_ready3, out_valid3, out_self3, out_last3;
  logic [7:0] out_n3;

  int   checks = 0;
  int   errors = 0;
  win_t q[$];
  win_t e;
  logic [7:0] cap_n [64];
  logic       cap_self [64];
  logic       cap_last [64];

  always #5 clk = ~clk;

  life_window_gen #(.WIDTH(8), .HEIGHT(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cell(in_cell),
    .out_valid(out_valid), .out_ready(out_ready), .out_self(out_self), .out_n(out_n),
    .out_last(out_last)
  );

  life_window_gen #(.WIDTH(3), .HEIGHT(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_cell(in_cell3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_self(out_self3), .out_n(out_n3),
    .out_last(out_last3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_n(input bit [63:0] b, input int w, input int h,
                                         input int r, input int c);
    logic [7:0] v;
    int dr, dc, rr, cc, idx;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      dr = (k < 3) ? -1 : (k < 5) ? 0 : 1;
      dc = (k == 0 || k == 3 || k == 5) ? -1 : (k == 1 || k == 6) ? 0 : 1;
      rr = r + dr;
      cc = c + dc;
`ifdef LIFE_WIN_TORUS_EN
      rr = (rr + h) % h;
      cc = (cc + w) % w;
      idx = rr * w + cc;
      v[k] = b[idx[5:0]];
`else
      idx = rr * w + cc;
      if (rr >= 0 && rr < h && cc >= 0 && cc < w) v[k] = b[idx[5:0]];
`endif
    end
    return v;
  endfunction

  task automatic push_frame(input bit [63:0] b, input int w, input int h);
    win_t x;
    int idx;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        idx    = r * w + c;
        x.self = b[idx[5:0]];
        x.n    = model_n(b, w, h, r, c);
        x.last = (r == h - 1) && (c == w - 1);
        q.push_back(x);
      end
  endtask

  // Entered and left on a negedge; inputs set here take effect at the next posedge.
  task automatic load_frame(input bit [63:0] b, input bit gaps);
    int i = 0, cyc = 0;
    push_frame(b, 8, 8);
    while (i < 64 && cyc < 1000) begin
      if (gaps && $urandom_range(0, 3) == 0) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_cell  = b[i[5:0]];
        if (in_ready) i++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("load_cnt", i, 64);
    check("load_to_emit_valid", out_valid, 1);
    check("load_to_emit_in_ready", in_ready, 0);
  endtask

  task automatic emit_frame(input int max_cnt, input int stall_idx, input int stall_len);
    int cnt = 0, cyc = 0, stall = 0;
    while (cnt < max_cnt && cyc < 1000) begin
      if (cnt == stall_idx && stall < stall_len) begin
        out_ready = 1'b0;
        stall++;
        check("stall_valid", out_valid, 1);
        check("stall_n", out_n, q[0].n);
        check("stall_self", out_self, q[0].self);
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          e = q.pop_front();
          check("win_self", out_self, e.self);
          check("win_n", out_n, e.n);
          check("win_last", out_last, e.last);
          cap_n[cnt] = out_n; cap_self[cnt] = out_self; cap_last[cnt] = out_last;
          cnt++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("emit_cnt", cnt, max_cnt);
  endtask

  task automatic emit_tail_check();
    check("emit_to_load_ready", in_ready, 1);
    check("emit_to_load_valid", out_valid, 0);
    check("queue_empty", q.size(), 0);
  endtask

  task automatic reset3();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_n", out_n, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_self", out_self, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
  endtask

  initial begin
    bit [63:0] b, b2;
    int i, cyc, cnt;
    @(negedge clk);
    reset3();

    // Reset mid-EMIT, then a fresh frame from (0,0)
    load_frame(64'hDEAD_BEEF_0F0F_A5A5, 1'b0);
    emit_frame(10, -1, 0);
    q.delete();
    reset3();
    load_frame(64'h0123_4567_89AB_CDEF, 1'b0);
    emit_frame(64, -1, 0);
    emit_tail_check();

    // Full board of ones
    load_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    emit_frame(64, -1, 0);
    emit_tail_check();
`ifdef LIFE_WIN_TORUS_EN
    check("ones_00", cap_n[0], 8'hFF);
    check("ones_77", cap_n[63], 8'hFF);
`else
    check("ones_00", cap_n[0], 8'b1101_0000);
    check("ones_77", cap_n[63], 8'b0000_1011);
`endif
    check("ones_33", cap_n[27], 8'hFF);
    check("ones_77_last", cap_last[63], 1);

    // Single live cell at (0,0)
    load_frame(64'h1, 1'b0);
    emit_frame(64, -1, 0);
    emit_tail_check();
    check("single_00_self", cap_self[0], 1);
    check("single_00_n", cap_n[0], 8'h00);
    check("single_11_nw", cap_n[9][0], 1);
`ifdef LIFE_WIN_TORUS_EN
    check("single_77_se", cap_n[63][7], 1);
    check("single_07_e", cap_n[7][4], 1);
`else
    check("single_77_n", cap_n[63], 8'h00);
    check("single_07_n", cap_n[7], 8'h00);
`endif

    // Backpressure at window (2,5)
    b = {$urandom(), $urandom()};
    load_frame(b, 1'b0);
    emit_frame(64, 21, 5);
    emit_tail_check();

    // Input gaps, then back-to-back second frame
    b  = {$urandom(), $urandom()};
    b2 = ~b ^ {$urandom(), $urandom()};
    load_frame(b, 1'b1);
    emit_frame(64, -1, 0);
    emit_tail_check();
    load_frame(b2, 1'b0);
    emit_frame(64, -1, 0);
    emit_tail_check();

    // 3x3 blinker on the minimum board
    b = 64'h0000_0000_0000_0038;
    push_frame(b, 3, 3);
    i = 0; cyc = 0;
    while (i < 9 && cyc < 200) begin
      in_valid3 = 1'b1;
      in_cell3  = b[i[5:0]];
      if (in_ready3) i++;
      @(negedge clk);
      cyc++;
    end
    in_valid3 = 1'b0;
    check("b3_load_valid", out_valid3, 1);
    cnt = 0; cyc = 0;
    while (cnt < 9 && cyc < 200) begin
      out_ready3 = 1'b1;
      if (out_valid3) begin
        e = q.pop_front();
        check("b3_self", out_self3, e.self);
        check("b3_n", out_n3, e.n);
        check("b3_last", out_last3, e.last);
        cap_n[cnt] = out_n3; cap_self[cnt] = out_self3;
        cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready3 = 1'b0;
    check("b3_cnt", cnt, 9);
    check("b3_done_ready", in_ready3, 1);
    check("b3_11_self", cap_self[4], 1);
`ifndef LIFE_WIN_TORUS_EN
    check("b3_01_n", cap_n[1], 8'b1110_0000);
    check("b3_11_n", cap_n[4], 8'b0001_1000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
